// File: rtl/farrow_resampler_mc_pkg.sv
// Shared constants, types and helpers for the multi-channel Farrow resampler.
//   Sizing constants : DW, CW, DEGREE, TAPS, CHANNELS, MUW, SIW, ACCW plus derived widths
//   Types            : state_e, sample_t, coef_t, acc_t, phase_t, step_t
//   Functions        : round_sat (accumulator -> sample), mac_latency (MAC start to out_valid)
package farrow_resampler_mc_pkg;

  localparam int unsigned DW       = 16;  // sample width, Q1.(DW-1)
  localparam int unsigned CW       = 18;  // coefficient width, Q2.(CW-2)
  localparam int unsigned DEGREE   = 3;   // polynomial degree
  localparam int unsigned TAPS     = 8;   // delay-line depth per channel
  localparam int unsigned CHANNELS = 2;   // channels per input beat
  localparam int unsigned MUW      = 16;  // fractional phase width
  localparam int unsigned SIW      = 4;   // integer bits of step
  localparam int unsigned ACCW     = 48;  // accumulator width

  localparam int unsigned NumCoef = (DEGREE + 1) * TAPS;
  localparam int unsigned CoefAw  = $clog2(NumCoef);
  localparam int unsigned StepW   = SIW + MUW;
  localparam int unsigned NeedW   = SIW + 1;  // holds (mu + step) >> MUW including the carry
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned KW      = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
  localparam int unsigned TW      = $clog2(TAPS + 1);  // TAPS product cycles + 1 Horner cycle
  localparam int unsigned TIW     = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {StNeed, StMac, StOut} state_e;

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [CW-1:0]   coef_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic        [MUW-1:0]  phase_t;
  typedef logic        [StepW-1:0] step_t;

  localparam acc_t RoundBias = acc_t'(2 ** (CW - 3));
  localparam acc_t SatMax    = acc_t'(2 ** (DW - 1) - 1);
  localparam acc_t SatMin    = -acc_t'(2 ** (DW - 1));

  // Accumulator carries DW-1+CW-2 fraction bits; drop CW-2 of them with round-half-up.
  function automatic sample_t round_sat(acc_t v);
    acc_t r;
    r = (v + RoundBias) >>> (CW - 2);
    if (r > SatMax) begin
      round_sat = sample_t'(SatMax);
    end else if (r < SatMin) begin
      round_sat = sample_t'(SatMin);
    end else begin
      round_sat = sample_t'(r);
    end
  endfunction

  // Cycles from the beat that starts a MAC run to out_valid rising.
  function automatic int unsigned mac_latency();
    return CHANNELS * (DEGREE + 1) * (TAPS + 1) + 1;
  endfunction

endpackage

// File: rtl/farrow_resampler_mc_if.sv
// Bus bundle for the Farrow resampler.
//   in_*   : sample source handshake (valid/ready) with packed channel data
//   step   : UQ(SIW).(MUW) input samples per output
//   coef_* : coefficient write port, address = k*TAPS + t
//   out_*  : consumer handshake with packed channel data
//   busy   : block is not waiting for input
// master = source/consumer side, slave = resampler side.
interface farrow_resampler_mc_if;
  import farrow_resampler_mc_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNELS*DW-1:0]   in_data;
  step_t                    step;
  logic                     coef_we;
  logic                     coef_ready;
  logic [CoefAw-1:0]        coef_addr;
  coef_t                    coef_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CHANNELS*DW-1:0]   out_data;
  logic                     busy;

  modport master (
    output in_valid, in_data, step, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, coef_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, step, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, coef_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/farrow_resampler_mc_coef_ram.sv
// Shared (DEGREE+1)*TAPS x CW coefficient store.
//   clk_i   : clock
//   we_i    : write strobe (already qualified by the caller)
//   waddr_i : write address k*TAPS + t
//   wdata_i : coefficient polyM[k][t]
//   raddr_i : read address from the MAC counters
//   rdata_o : asynchronous read data
// Contents are deliberately not reset.
module farrow_resampler_mc_coef_ram
  import farrow_resampler_mc_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [CoefAw-1:0] waddr_i,
  input  coef_t             wdata_i,
  input  logic [CoefAw-1:0] raddr_i,
  output coef_t             rdata_o
);

  coef_t mem_q [2**CoefAw];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/farrow_resampler_mc.sv
// Multi-channel fixed-point Farrow fractional resampler, single clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of farrow_resampler_mc_if (input beats, step, coefficient
//           writes, output beats, busy)
// Each channel keeps a TAPS-deep delay line (x[0] newest). One shared MAC walks
// channel -> k = DEGREE..0 -> TAPS product cycles + 1 Horner cycle, then the
// rounded results are published in a single OUT cycle.
module farrow_resampler_mc
  import farrow_resampler_mc_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  farrow_resampler_mc_if.slave bus
);

  localparam int unsigned PrW = CW + DW;
  localparam int unsigned HmW = ACCW + MUW + 1;

  state_e                 state_q;
  sample_t                x_q   [CHANNELS][TAPS];
  sample_t                res_q [CHANNELS];
  phase_t                 mu_q;
  logic [NeedW-1:0]       need_q;
  logic [ChW-1:0]         ch_q;
  logic [KW-1:0]          k_q;
  logic [TW-1:0]          t_q;
  acc_t                   acc_q;
  acc_t                   h_q;
  logic [CHANNELS*DW-1:0] out_data_q;
  logic                   out_valid_q;

  logic                   coef_we_ok;
  logic [CoefAw-1:0]      coef_raddr;
  coef_t                  coef_rd;
  logic [TIW-1:0]         t_idx;
  sample_t                x_sel;
  logic signed [PrW-1:0]  prod_raw;
  acc_t                   prod;
  acc_t                   h_cur;
  logic signed [HmW-1:0]  h_mul;
  acc_t                   h_new;
  logic [StepW:0]         phase_sum;
  logic                   t_last;
  logic                   k_last;
  logic                   ch_last;

  assign bus.in_ready   = (state_q == StNeed);
  assign bus.coef_ready = (state_q == StNeed);
  assign bus.busy       = (state_q != StNeed);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  assign coef_we_ok = bus.coef_we && (state_q == StNeed);

  farrow_resampler_mc_coef_ram u_coef_ram (
    .clk_i   (clk),
    .we_i    (coef_we_ok),
    .waddr_i (bus.coef_addr),
    .wdata_i (bus.coef_data),
    .raddr_i (coef_raddr),
    .rdata_o (coef_rd)
  );

  always_comb begin
    t_idx      = t_q[TIW-1:0];
    t_last     = (t_q == TW'(TAPS));
    k_last     = (k_q == '0);
    ch_last    = (ch_q == ChW'(CHANNELS - 1));
    coef_raddr = CoefAw'(32'(k_q) * TAPS + 32'(t_idx));
    x_sel      = x_q[ch_q][t_idx];
    prod_raw   = PrW'(coef_rd) * PrW'(x_sel);
    prod       = acc_t'(prod_raw);
    // Horner starts from zero on the highest-order row of each channel.
    h_cur      = (k_q == KW'(DEGREE)) ? '0 : h_q;
    h_mul      = HmW'(h_cur) * HmW'($signed({1'b0, mu_q}));
    h_new      = acc_t'(h_mul >>> MUW) + acc_q;
    phase_sum  = (StepW + 1)'(mu_q) + (StepW + 1)'(bus.step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StNeed;
      mu_q        <= '0;
      need_q      <= NeedW'(1);
      ch_q        <= '0;
      k_q         <= KW'(DEGREE);
      t_q         <= '0;
      acc_q       <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        res_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          x_q[c][t] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StNeed: begin
          if (bus.in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
              x_q[c][0] <= sample_t'(bus.in_data[c*DW +: DW]);
              for (int t = 1; t < TAPS; t++) begin
                x_q[c][t] <= x_q[c][t-1];
              end
            end
            need_q <= need_q - NeedW'(1);
            if (need_q == NeedW'(1)) begin
              state_q <= StMac;
            end
          end
        end

        StMac: begin
          if (!t_last) begin
            acc_q <= acc_q + prod;
            t_q   <= t_q + TW'(1);
          end else begin
            acc_q <= '0;
            t_q   <= '0;
            if (k_last) begin
              res_q[ch_q] <= round_sat(h_new);
              h_q         <= '0;
              k_q         <= KW'(DEGREE);
              if (ch_last) begin
                ch_q    <= '0;
                state_q <= StOut;
              end else begin
                ch_q <= ch_q + ChW'(1);
              end
            end else begin
              h_q <= h_new;
              k_q <= k_q - KW'(1);
            end
          end
        end

        StOut: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
              out_data_q[c*DW +: DW] <= res_q[c];
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            mu_q        <= phase_sum[MUW-1:0];
            need_q      <= phase_sum[StepW:MUW];
            // No whole input sample to consume: interpolate again from the same history.
            state_q     <= (phase_sum[StepW:MUW] == '0) ? StMac : StNeed;
          end
        end

        default: state_q <= StNeed;
      endcase
    end
  end

endmodule
